// File: rtl/stepper_seq_if.sv
// Command channel of the stepper sequencer: valid/ready handshake plus the move
// parameters (direction, drive mode, step count, step period).
interface stepper_seq_if #(
  parameter int DIV_W = 21,
  parameter int CNT_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_mode, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_mode, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/stepper_seq.sv
// Stepper-motor sequencer: executes wave / full two-phase / half-step moves on
// four active-low coils, tracks position. Optional macro: STEPPER_RELEASE_EN.
module stepper_seq #(
  parameter int DIV_W = 21,
  parameter int CNT_W = 16,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  stepper_seq_if.slave     cmd_if,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [3:0]       out,
  output logic [POS_W-1:0] position
);

`ifdef STEPPER_RELEASE_EN
  localparam bit       RELEASE   = 1'b1;
  localparam bit [3:0] RESET_OUT = 4'b1111;
`else
  localparam bit       RELEASE   = 1'b0;
  localparam bit [3:0] RESET_OUT = 4'b0111;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       idx_reg, idx_next;
  logic [3:0]       out_reg, out_next;
  logic [POS_W-1:0] position_reg, position_next;
  logic [DIV_W-1:0] timer_reg, timer_next;
  logic [DIV_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             dir_reg, dir_next;
  logic             half_reg, half_next;
  logic             done_reg, done_next;

  logic             accept;
  logic [2:0]       idx_aligned;
  logic [2:0]       idx_stepped;
  logic [2:0]       idx_mag;
  logic [POS_W-1:0] pos_mag;

  function automatic logic [3:0] phase(input logic [2:0] i);
    case (i)
      3'd0:    phase = 4'b0111;
      3'd1:    phase = 4'b0011;
      3'd2:    phase = 4'b1011;
      3'd3:    phase = 4'b1001;
      3'd4:    phase = 4'b1101;
      3'd5:    phase = 4'b1100;
      3'd6:    phase = 4'b1110;
      default: phase = 4'b0110;
    endcase
  endfunction

  assign cmd_if.cmd_ready = (state_reg == IDLE) && !rst;
  assign accept           = cmd_if.cmd_valid && (state_reg == IDLE);

  // Wave (and the unused mode 3) sits on even indices, full two-phase on odd.
  always_comb begin
    case (cmd_if.cmd_mode)
      2'd1:    idx_aligned = {idx_reg[2:1], 1'b1};
      2'd2:    idx_aligned = idx_reg;
      default: idx_aligned = {idx_reg[2:1], 1'b0};
    endcase
  end

  assign idx_mag     = half_reg ? 3'd1 : 3'd2;
  assign pos_mag     = half_reg ? POS_W'(1) : POS_W'(2);
  assign idx_stepped = dir_reg ? idx_reg + idx_mag : idx_reg - idx_mag;

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    out_next       = out_reg;
    position_next  = position_reg;
    timer_next     = timer_reg;
    period_next    = period_reg;
    remaining_next = remaining_reg;
    dir_next       = dir_reg;
    half_next      = half_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          dir_next       = cmd_if.cmd_dir;
          half_next      = (cmd_if.cmd_mode == 2'd2);
          period_next    = cmd_if.cmd_period;
          remaining_next = cmd_if.cmd_steps;
          timer_next     = '0;
          idx_next       = idx_aligned;
          out_next       = phase(idx_aligned);
          if (cmd_if.cmd_steps == '0) begin
            done_next = 1'b1;
            if (RELEASE) out_next = 4'b1111;
          end else begin
            state_next = RUN;
          end
        end
      end
      default: begin
        // Abort wins over a coinciding tick so position always matches the coils.
        if (abort) begin
          state_next = IDLE;
          if (RELEASE) out_next = 4'b1111;
        end else if (timer_reg == period_reg) begin
          timer_next     = '0;
          idx_next       = idx_stepped;
          out_next       = phase(idx_stepped);
          remaining_next = remaining_reg - CNT_W'(1);
          position_next  = dir_reg ? position_reg + pos_mag : position_reg - pos_mag;
          if (remaining_reg == CNT_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
            if (RELEASE) out_next = 4'b1111;
          end
        end else begin
          timer_next = timer_reg + DIV_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      out_reg       <= RESET_OUT;
      position_reg  <= '0;
      timer_reg     <= '0;
      period_reg    <= '0;
      remaining_reg <= '0;
      dir_reg       <= 1'b0;
      half_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_reg       <= out_next;
      position_reg  <= position_next;
      timer_reg     <= timer_next;
      period_reg    <= period_next;
      remaining_reg <= remaining_next;
      dir_reg       <= dir_next;
      half_reg      <= half_next;
      done_reg      <= done_next;
    end
  end

  assign busy     = (state_reg == RUN);
  assign done     = done_reg;
  assign out      = out_reg;
  assign position = position_reg;

endmodule

// File: tb/tb_stepper_seq.sv
// Scoreboard bench for stepper_seq: the driver predicts per-edge coil/position
// observations from the phase table; a monitor pops and compares them.
module tb_stepper_seq;
  localparam int DIV_W = 21;
  localparam int CNT_W = 16;
  localparam int POS_W = 16;
`ifdef STEPPER_RELEASE_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic [3:0]       out;
  logic [POS_W-1:0] position;

  stepper_seq_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) cmd_if ();

  stepper_seq #(.DIV_W(DIV_W), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_if   (cmd_if),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .position (position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [3:0]   out;
    logic [15:0]  pos;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t              q[$];
  int                vectors = 0;
  int                miscompares = 0;
  logic [3:0]        ph [8] = '{4'b0111, 4'b0011, 4'b1011, 4'b1001,
                                4'b1101, 4'b1100, 4'b1110, 4'b0110};
  int                m_idx = 0;
  logic signed [15:0] m_pos = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  endtask

  // Monitor: compares every predicted observation on the edge it belongs to.
  always @(negedge clk) begin
    if (!rst) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        miscompares++;
        $display("FAIL missed_entry: expected at cyc %0d, now %0d", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("out",       32'(out),           32'(e.out));
        check("position",  32'(position),      32'(e.pos));
        check("busy",      32'(busy),          32'(e.busy));
        check("done",      32'(done),          32'(e.done));
        check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(!e.busy));
      end else if (done) begin
        miscompares++;
        $display("FAIL unexpected_done @cyc %0d: got 1 expected 0", cyc);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_idx = 0;
    m_pos = '0;
    @(posedge clk);
    #1;
    check("rst_out",      32'(out),      REL ? 32'hF : 32'h7);
    check("rst_position", 32'(position), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_done",     32'(done),     32'h0);
    check("rst_ready",    32'(cmd_if.cmd_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one command and predicts its full trace. abort_at = edges after the
  // accept edge at which abort is sampled (0 = none); hold keeps abort high after.
  task automatic issue(input bit dir, input logic [1:0] mode, input int steps,
                       input int period, input int abort_at, input bit hold);
    int   w;
    int   e0;
    int   d;
    int   ntaken;
    bit   aborted;
    bit   last;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!cmd_if.cmd_ready) begin
      @(negedge clk);
      w++;
      if (w > 70000) begin
        miscompares++;
        vectors++;
        $display("FAIL ready_timeout: got cmd_ready 0 expected 1 within 70000 cycles");
        summary();
      end
    end
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_dir    = dir;
    cmd_if.cmd_mode   = mode;
    cmd_if.cmd_steps  = CNT_W'(steps);
    cmd_if.cmd_period = DIV_W'(period);
    e0 = cyc + 1;

    if (mode == 2'd1)      m_idx = m_idx | 1;
    else if (mode != 2'd2) m_idx = m_idx & 6;
    d = (mode == 2'd2) ? 1 : 2;
    if (!dir) d = -d;
    aborted = (abort_at > 0) && (abort_at <= steps * (period + 1));
    ntaken  = aborted ? (abort_at - 1) / (period + 1) : steps;

    e.cyc = e0; e.pos = m_pos; e.busy = (steps != 0); e.done = (steps == 0);
    e.out = (steps == 0 && REL) ? 4'hF : ph[m_idx];
    q.push_back(e);
    for (int k = 1; k <= ntaken; k++) begin
      m_idx = (m_idx + d + 8) % 8;
      m_pos = m_pos + 16'(d);
      last  = !aborted && (k == steps);
      e.cyc = e0 + k * (period + 1);
      e.out = (last && REL) ? 4'hF : ph[m_idx];
      e.pos = m_pos; e.busy = !last; e.done = last;
      q.push_back(e);
    end
    if (aborted) begin
      e.cyc = e0 + abort_at; e.out = REL ? 4'hF : ph[m_idx];
      e.pos = m_pos; e.busy = 1'b0; e.done = 1'b0;
      q.push_back(e);
    end

    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    abort = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = hold;
      if (hold) repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_dir    = 1'b0;
    cmd_if.cmd_mode   = 2'd0;
    cmd_if.cmd_steps  = '0;
    cmd_if.cmd_period = '0;

    do_reset();
    issue(1'b1, 2'd0, 4, 3, 0, 1'b0);     // wave fwd
    do_reset();
    issue(1'b0, 2'd2, 3, 0, 0, 1'b0);     // half rev, P=0
    do_reset();
    issue(1'b1, 2'd1, 2, 1, 0, 1'b0);     // full fwd, alignment to odd
    issue(1'b1, 2'd0, 10, 2, 6, 1'b1);    // abort on second tick, held in IDLE
    issue(1'b0, 2'd1, 0, 5, 0, 1'b0);     // zero steps, accepted with abort high
    issue(1'b1, 2'd2, 2, 0, 0, 1'b0);     // back-to-back after a done

    for (int n = 0; n < 40; n++) begin
      bit         dir;
      logic [1:0] mode;
      int         steps;
      int         period;
      int         ab;
      dir    = 1'($urandom % 2);
      mode   = 2'($urandom % 4);
      steps  = int'($urandom_range(0, 6));
      period = int'($urandom_range(0, 4));
      ab     = 0;
      if (steps != 0 && ($urandom % 4) == 0)
        ab = int'($urandom_range(1, steps * (period + 1) + 2));
      issue(dir, mode, steps, period, ab, 1'($urandom % 2));
    end

    issue(1'b1, 2'd0, 50, 1, 0, 1'b0);    // interrupted by reset
    repeat (10) @(negedge clk);
    do_reset();
    repeat (5) @(negedge clk);

    issue(1'b1, 2'd2, 32768, 0, 0, 1'b0); // half-step wrap to -32768

    for (int w = 0; q.size() > 0; w++) begin
      @(negedge clk);
      if (w > 70000) begin
        miscompares++;
        vectors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        break;
      end
    end
    repeat (4) @(negedge clk);
    check("final_position", 32'(position), 32'(16'h8000));
    summary();
  end
endmodule

// File: doc/stepper_seq.md
# stepper_seq

Parametrised stepper-motor sequencer that supersedes the fixed free-running 4-phase driver. It accepts step commands over a valid/ready handshake, each carrying direction, drive mode (wave, full two-phase or half-step), step count and step period, and drives the four active-low coil outputs. It also tracks absolute position and supports abort. It sits between the board-level control logic and the coil driver pins.

## Interface
- `DIV_W`, default 21: width of the step-period prescaler and of `cmd_period`.
- `CNT_W`, default 16: width of `cmd_steps` and of the remaining-step counter.
- `POS_W`, default 16: width of `position`, in half-step units.

- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high in IDLE when `rst`=0; accept = `cmd_valid & cmd_ready`.
- `cmd_dir`  in  1  1 = forward (index increments), 0 = reverse.
- `cmd_mode`  in  2  0 = wave, 1 = full two-phase, 2 = half-step, 3 = treated as wave.
- `cmd_steps`  in  CNT_W  number of steps to take.
- `cmd_period`  in  DIV_W  a step occurs every `cmd_period`+1 clocks.
- `abort`  in  1  stop the current move.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a move completes normally.
- `out`  out  4  coil drive, active-low.
- `position`  out  POS_W  signed position in half-steps; two's-complement wrap.

## Operation
- Phase table H[0..7] = 0111, 0011, 1011, 1001, 1101, 1100, 1110, 0110. The 3-bit index `idx` selects the entry and `out` = H[idx], registered.
- Wave mode uses even `idx` and steps ±2. Full two-phase mode uses odd `idx` and steps ±2. Half-step mode steps ±1. All index arithmetic is mod 8.
- The FSM has two states, IDLE and RUN.
- On accept in IDLE:
  - Latch dir, mode, steps and period. Clear the timer.
  - Align `idx`: wave clears idx[0]; full sets idx[0]; half leaves it unchanged. Drive `out` = H[aligned idx] on the same edge.
  - Alignment does not change `position`.
  - If `cmd_steps`=0: stay in IDLE and pulse `done` on the next cycle. Otherwise go to RUN.
- In RUN, the timer increments each clock. When timer == latched period:
  - Clear the timer and take one step: update `idx` and `out`, decrement the remaining count, and add ±1 (half) or ±2 (wave/full) to `position`.
  - If the step was the last one (remaining was 1), go to IDLE and assert `done` for exactly the following cycle.
- Abort in RUN: go to IDLE on that edge. No step is taken even if a tick coincides. `done` is not pulsed and `position` stays accurate.
- Abort in IDLE is ignored. Abort and `cmd_valid` together in IDLE: the command is accepted.
- `cmd_valid` in RUN is not accepted; `cmd_ready`=0 there.
- Reset values: `out`=0111 (1111 with the release macro), `idx`=0, `position`=0, `busy`=0, `done`=0, state IDLE, timer 0. `cmd_ready`=0 while `rst`=1. Reset mid-move discards the move with no `done` pulse.

## Timing
- Accept at edge E0 gives the first step at edge E0+(P+1), then every P+1 edges, where P is the latched period.
- An N-step move completes at edge E0+N(P+1). `done` is high in the cycle after that edge, and `cmd_ready` is high in the same cycle.
- `busy` rises in the cycle after accept and falls in the cycle after the last step or abort.
- P=0 means one step per clock.
- Back-to-back moves: a new command can be accepted in the cycle where `done` is high.

## Configuration
- `STEPPER_RELEASE_EN` defined:
  - Whenever the state is IDLE (after reset, `done`, abort, or a zero-step command), `out`=1111 (coils de-energised) from the edge that enters IDLE.
  - `idx` is retained. On accept, `out` = H[aligned idx] on the accept edge.
- `STEPPER_RELEASE_EN` undefined: `out` holds the last phase in IDLE, and the reset value is 0111.

## Test plan
- Reset, then wave, fwd, steps=4, P=3 accepted at E0 → `out` is 1011, 1101, 1110, 0111 at E4, E8, E12 and E16; `done` is high in the cycle after E16; `position`=8.
- Half-step, rev, steps=3, P=0 from `idx`=0 → `out` is 0110, 1110, 1100 on consecutive edges; `position`=-3; `busy` is high for exactly 3 cycles.
- Full mode accepted with `idx`=0 → aligned to `idx`=1 (`out`=0011) on the accept edge; with fwd, steps=2, `out` is 1001 then 1100; `position`=+4.
- Abort asserted on the same edge as the second tick of a steps=10, P=2 move → exactly 1 step taken, no `done`, `cmd_ready` high on the next cycle; abort held high in IDLE has no effect.
- `cmd_steps`=0 → `busy` stays 0, `done` pulses once, `out` and `position` are unchanged (except alignment). 32768 forward half-steps from 0 → `position` wraps to -32768 (POS_W=16).
- With `STEPPER_RELEASE_EN`: `out`=1111 after reset and after `done`; on the next accept, `out` restores H[aligned idx].
